calculate_ntlm: RTL and testbench



---
 rtl/calculate_ntlm_if.sv | 26 ++
 rtl/calculate_ntlm.sv | 168 ++++++++++++++++
 tb/tb_calculate_ntlm.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/calculate_ntlm_if.sv
// Bus between the candidate generator and the NTLM hashing core.
// start is a request accepted only while busy is low; done is a one-cycle result strobe.
interface calculate_ntlm_if;
    logic          start;
    logic [0:127]  instr;
    logic [0:3]    length;
    logic [0:511]  buff;
    logic [0:31]   a4;
    logic [0:31]   b4;
    logic [0:31]   c4;
    logic [0:31]   d4;
    logic [0:127]  hash;
    logic          busy;
    logic          done;
    logic [1:0]    state;

    modport master (
        output start, instr, length,
        input  buff, a4, b4, c4, d4, hash, busy, done, state
    );

    modport slave (
        input  start, instr, length,
        output buff, a4, b4, c4, d4, hash, busy, done, state
    );
endinterface

// File: rtl/calculate_ntlm.sv
// NTLM core: builds the UTF-16LE padded MD4 block from a password and runs
// the 48 MD4 steps one per clock, then publishes the byte-ordered digest.
module calculate_ntlm (
    input logic             clk,
    input logic             n_rst,
    calculate_ntlm_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    logic [1:0]   state_r;
    logic [5:0]   step_r;
    logic [0:511] buff_r;
    logic [31:0]  a_r, b_r, c_r, d_r;
    logic [0:127] hash_r;
    logic         busy_r;
    logic         done_r;

    logic [3:0]   len_in;
    logic [0:511] nt_next;
    logic [15:0]  half;

    logic [1:0]   rnd;
    logic [3:0]   idx;
    logic [3:0]   x_idx;
    logic [4:0]   sh;
    logic [31:0]  f_val;
    logic [31:0]  k_const;
    logic [31:0]  x_word;
    logic [31:0]  sum;
    logic [31:0]  rot;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign len_in = bus.length;

    // Char c sits in word c/2: even chars in the low 16 bits, odd chars in the high 16 bits.
    always_comb begin
        nt_next = '0;
        half    = 16'h0000;
        for (int c = 0; c < 16; c++) begin
            half = 16'h0000;
            if (4'(c) < len_in)
                half = {8'h00, bus.instr[8*c +: 8]};
            else if (4'(c) == len_in)
                half = 16'h0080;
            nt_next[32*(c/2) + 16*(1 - (c % 2)) +: 16] = half;
        end
        nt_next[448 +: 32] = {24'h000000, len_in, 4'h0};
    end

    assign rnd = step_r[5:4];
    assign idx = step_r[3:0];

    // Round 2 walks message words column-wise, round 3 in bit-reversed order.
    always_comb begin
        f_val   = '0;
        k_const = '0;
        x_idx   = '0;
        sh      = '0;
        case (rnd)
            2'd0: begin
                f_val   = (b_r & c_r) | (~b_r & d_r);
                k_const = 32'h00000000;
                x_idx   = idx;
                case (idx[1:0])
                    2'd0:    sh = 5'd3;
                    2'd1:    sh = 5'd7;
                    2'd2:    sh = 5'd11;
                    default: sh = 5'd19;
                endcase
            end
            2'd1: begin
                f_val   = (b_r & c_r) | (b_r & d_r) | (c_r & d_r);
                k_const = 32'h5a827999;
                x_idx   = {idx[1:0], idx[3:2]};
                case (idx[1:0])
                    2'd0:    sh = 5'd3;
                    2'd1:    sh = 5'd5;
                    2'd2:    sh = 5'd9;
                    default: sh = 5'd13;
                endcase
            end
            default: begin
                f_val   = b_r ^ c_r ^ d_r;
                k_const = 32'h6ed9eba1;
                x_idx   = {idx[0], idx[1], idx[2], idx[3]};
                case (idx[1:0])
                    2'd0:    sh = 5'd3;
                    2'd1:    sh = 5'd9;
                    2'd2:    sh = 5'd11;
                    default: sh = 5'd15;
                endcase
            end
        endcase
    end

    assign x_word = buff_r[{x_idx, 5'b00000} +: 32];
    assign sum    = a_r + f_val + x_word + k_const;
    assign rot    = (sum << sh) | (sum >> (6'd32 - {1'b0, sh}));

    // Working registers rotate (a,b,c,d) <- (d,new,b,c); after 48 steps a is back in place.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
            step_r  <= '0;
            buff_r  <= '0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            d_r     <= '0;
            hash_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        buff_r  <= nt_next;
                        a_r     <= IV_A;
                        b_r     <= IV_B;
                        c_r     <= IV_C;
                        d_r     <= IV_D;
                        step_r  <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_r    <= d_r;
                    b_r    <= rot;
                    c_r    <= b_r;
                    d_r    <= c_r;
                    step_r <= step_r + 6'd1;
                    if (step_r == 6'd47)
                        state_r <= ST_FINAL;
                end
                ST_FINAL: begin
                    hash_r  <= {bswap(a_r + IV_A), bswap(b_r + IV_B),
                                bswap(c_r + IV_C), bswap(d_r + IV_D)};
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.buff  = buff_r;
    assign bus.a4    = a_r;
    assign bus.b4    = b_r;
    assign bus.c4    = c_r;
    assign bus.d4    = d_r;
    assign bus.hash  = hash_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.state = state_r;
endmodule

// File: tb/tb_calculate_ntlm.sv
// Bench for calculate_ntlm: directed passwords, known NTLM digests and a
// byte-stream MD4 model for the cases without a published digest.
module tb_calculate_ntlm;
    logic clk;
    logic n_rst;

    int n_checks;
    int n_fail;

    logic [127:0] exp_q[$];
    logic [31:0]  mw[16];

    int r2k[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int r3k[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int s1[4]   = '{3, 7, 11, 19};
    int s2[4]   = '{3, 5, 9, 13};
    int s3[4]   = '{3, 9, 11, 15};

    calculate_ntlm_if bus();

    calculate_ntlm dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] buff_word(input int i);
        return bus.buff[32*i +: 32];
    endfunction

    function automatic logic [0:127] pack_str(input string s, input logic [7:0] fill);
        logic [0:127] r;
        r = {16{fill}};
        for (int i = 0; i < s.len(); i++)
            r[8*i +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] bs(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // ---------------- model ----------------
    // Message block as the byte stream MD4 sees it: UTF-16LE chars, 0x80, bit count at byte 56.
    task automatic model_load(input logic [0:127] pw, input int len);
        logic [7:0] mbytes[64];
        for (int i = 0; i < 64; i++) mbytes[i] = 8'h00;
        for (int c = 0; c < len; c++) mbytes[2*c] = pw[8*c +: 8];
        mbytes[2*len] = 8'h80;
        mbytes[56]    = 8'(len * 16);
        for (int w = 0; w < 16; w++)
            mw[w] = {mbytes[4*w+3], mbytes[4*w+2], mbytes[4*w+1], mbytes[4*w]};
    endtask

    task automatic model_md4(output logic [31:0] ra, output logic [31:0] rb,
                             output logic [31:0] rc, output logic [31:0] rd);
        logic [31:0] a, b, c, d, t, f, kk;
        int k, s;
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 48; i++) begin
            if (i < 16) begin
                f = (b & c) | (~b & d); kk = 32'h0; k = i; s = s1[i % 4];
            end else if (i < 32) begin
                f = (b & c) | (b & d) | (c & d); kk = 32'h5a827999; k = r2k[i-16]; s = s2[i % 4];
            end else begin
                f = b ^ c ^ d; kk = 32'h6ed9eba1; k = r3k[i-32]; s = s3[i % 4];
            end
            t = rotl(a + f + mw[k] + kk, s);
            a = d; d = c; c = b; b = t;
        end
        ra = a; rb = b; rc = c; rd = d;
    endtask

    // ---------------- driver ----------------
    task automatic run_job(input string tag, input logic [0:127] pw, input int len,
                           input bit known, input logic [127:0] known_hash, input int poke_at);
        logic [31:0] ma, mbv, mc, md;
        logic [127:0] exp_hash;
        int lat;
        int pulses;
        model_load(pw, len);
        model_md4(ma, mbv, mc, md);
        exp_hash = known ? known_hash
                         : {bs(ma + 32'h67452301), bs(mbv + 32'hefcdab89),
                            bs(mc + 32'h98badcfe), bs(md + 32'h10325476)};
        exp_q.push_back(exp_hash);

        @(negedge clk);
        bus.instr  = pw;
        bus.length = 4'(len);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.instr  = {$urandom, $urandom, $urandom, $urandom};
        bus.length = 4'($urandom_range(0, 15));
        check({tag, "_busy_e0"}, 128'(bus.busy), 128'd1);
        for (int w = 0; w < 16; w++)
            check($sformatf("%s_buff_w%0d", tag, w), 128'(buff_word(w)), 128'(mw[w]));

        lat = 0;
        while (!bus.done && lat < 60) begin
            @(negedge clk);
            lat++;
            bus.start = (poke_at > 0 && lat == poke_at - 1);
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, 128'(bus.done), 128'd1);
        check({tag, "_latency"}, 128'(lat), 128'd49);
        check({tag, "_busy_at_done"}, 128'(bus.busy), 128'd0);
        check({tag, "_hash"}, bus.hash, exp_q.pop_front());
        check({tag, "_regs"}, {bus.a4, bus.b4, bus.c4, bus.d4}, {ma, mbv, mc, md});
        @(negedge clk);
        check({tag, "_done_pulse"}, 128'(bus.done), 128'd0);

        if (poke_at > 0) begin
            pulses = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (bus.done) pulses++;
            end
            check({tag, "_extra_done"}, 128'(pulses), 128'd0);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        n_rst      = 1'b0;
        bus.start  = 1'b0;
        bus.instr  = '0;
        bus.length = '0;

        #12;
        check("rst_buff_lo", 128'(bus.buff[0:127]), 128'd0);
        check("rst_buff_hi", 128'(bus.buff[384:511]), 128'd0);
        check("rst_hash", bus.hash, 128'd0);
        check("rst_regs", {bus.a4, bus.b4, bus.c4, bus.d4}, 128'd0);
        check("rst_busy_done", {126'd0, bus.busy, bus.done}, 128'd0);
        check("rst_state", 128'(bus.state), 128'd0);
        @(negedge clk);
        n_rst = 1'b1;

        run_job("passwo", pack_str("passwo", 8'h00), 6, 1'b0, 128'd0, 0);
        check("passwo_w0", 128'(buff_word(0)), 128'h00610070);
        check("passwo_w1", 128'(buff_word(1)), 128'h00730073);
        check("passwo_w2", 128'(buff_word(2)), 128'h006f0077);
        check("passwo_w3", 128'(buff_word(3)), 128'h00000080);
        check("passwo_w14", 128'(buff_word(14)), 128'h00000060);

        run_job("password", pack_str("password", 8'h00), 8, 1'b1,
                128'h8846f7eaee8fb117ad06bdd830b7586c, 0);
        check("password_w4", 128'(buff_word(4)), 128'h00000080);
        check("password_w14", 128'(buff_word(14)), 128'h00000080);

        run_job("empty", {128{1'b1}}, 0, 1'b1,
                128'h31d6cfe0d16ae931b73c59d7e0c089c0, 0);
        check("empty_w0", 128'(buff_word(0)), 128'h00000080);
        check("empty_w1", 128'(buff_word(1)), 128'h00000000);
        check("empty_w14", 128'(buff_word(14)), 128'h00000000);

        run_job("junk", pack_str("password", 8'ha5), 8, 1'b1,
                128'h8846f7eaee8fb117ad06bdd830b7586c, 20);

        // Reset mid-run, just before step 25 completes.
        @(negedge clk);
        bus.instr  = pack_str("passwo", 8'h00);
        bus.length = 4'd6;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (24) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("midrst_buff_lo", 128'(bus.buff[0:127]), 128'd0);
        check("midrst_buff_hi", 128'(bus.buff[384:511]), 128'd0);
        check("midrst_hash", bus.hash, 128'd0);
        check("midrst_regs", {bus.a4, bus.b4, bus.c4, bus.d4}, 128'd0);
        check("midrst_busy_done", {126'd0, bus.busy, bus.done}, 128'd0);
        check("midrst_state", 128'(bus.state), 128'd0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_idle_done", 128'(bus.done), 128'd0);

        run_job("after_rst", pack_str("password", 8'h00), 8, 1'b1,
                128'h8846f7eaee8fb117ad06bdd830b7586c, 0);

        run_job("len15", pack_str("abcdefghijklmno", 8'h00), 15, 1'b0, 128'd0, 0);
        check("len15_w7", 128'(buff_word(7)), 128'h0080006f);
        check("len15_w14", 128'(buff_word(14)), 128'h000000f0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
